if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage producer for the IF/ID pipeline register.
- Owns the PC and runs a variable-latency req/ack read on instruction memory.
- Each cycle it presents either a fetched instruction with its PC+4, or a NOP bubble (all zeros).
- Obeys the hazard-detection stall and the branch/jump redirects from ID; their flush lines also clear IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address after start.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  leave IDLE and begin fetching; sampled only in IDLE
hd_stall_i  input  1  hazard-detection stall; hold current instruction and PC
branch_i  input  1  taken branch resolved in ID (same signal as IF/ID Flush1)
branch_target_i  input  32  branch target address
jump_i  input  1  jump decoded in ID (same signal as IF/ID Flush2)
jump_target_i  input  32  jump target address
imem_req_o  output  1  instruction memory read request
imem_addr_o  output  32  read address; stable while imem_req_o=1
imem_ack_i  input  1  read complete; imem_rdata_i valid this cycle
imem_rdata_i  input  32  instruction word
fetch_valid_o  output  1  instr_o/pc_plus4_o carry a real instruction
instr_o  output  32  instruction to IF/ID; 0 when fetch_valid_o=0
pc_plus4_o  output  32  PC+4 to IF/ID; 0 when fetch_valid_o=0
pc_o  output  32  current PC (debug/trace)

Behaviour:
- Reset (async, any time, including mid-request): state=IDLE, pc=RESET_PC, imem_req_o=0, fetch_valid_o=0, instr_o=0, pc_plus4_o=0, pending target=0.
- Memory protocol: imem_req_o and imem_addr_o stay constant until the cycle imem_ack_i=1. The ack completes the request on that edge. imem_ack_i is ignored while imem_req_o=0. Minimum latency is 1 cycle (ack is sampled no earlier than the cycle after req rises).
- Redirect:
  - redirect = branch_i | jump_i.
  - target = branch_target_i if branch_i, else jump_target_i. Branch wins if both are asserted.
  - A redirect overrides hd_stall_i.
  - Targets are used unmodified.
- PC+4 arithmetic is modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- States:
  - IDLE: req=0, valid=0. start_i=1 -> FETCH.
  - FETCH: req=1, addr=pc, valid=0.
    - ack & !redirect -> latch rdata, -> READY.
    - ack & redirect -> drop data, pc<=target, stay FETCH (new req at new address next cycle).
    - !ack & redirect -> pending<=target, -> DISCARD.
  - DISCARD: req=1, addr=old pc held, valid=0.
    - Another redirect overwrites pending (most recent wins).
    - On ack -> drop data, pc<=pending (or the new target if a redirect coincides), -> FETCH.
  - READY: valid=1, instr_o=latched word, pc_plus4_o=pc+4, req=0.
    - redirect -> pc<=target, -> FETCH; the instruction is discarded, valid falls next cycle.
    - else !hd_stall_i -> pc<=pc+4, -> FETCH (IF/ID captures the instruction on this edge).
    - else (stall) -> hold all outputs unchanged, any number of cycles.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory. Bubbles (valid=0, zeros) are presented during every FETCH/DISCARD cycle.
- start_i is ignored outside IDLE; only reset returns to IDLE.
- pc_o always equals the internal pc register.

Test Plan:
- Reset/start: rst_i pulse, start_i=1, ack 1 cycle after each req with rdata=32'h2002_0005 -> imem_addr_o=0, then instr_o=32'h2002_0005, pc_plus4_o=4, fetch_valid_o=1; next req addr=4.
- Stall hold: in READY at pc=8, hd_stall_i=1 for 3 cycles -> instr_o/pc_plus4_o=12 constant and imem_req_o=0 for 3 cycles; on release, next req addr=12.
- Redirect during wait: req at addr=16 with ack delayed 4 cycles, branch_i=1 with target 32'h40 in cycle 1 -> addr stays 16 until ack, data dropped, next req addr=32'h40, no valid instruction from addr 16.
- Simultaneous branch and jump in READY: branch target 32'h80, jump target 32'hC0, also hd_stall_i=1 -> next req addr=32'h80, fetch_valid_o=0 the next cycle.
- Wrap and async reset: pc=32'hFFFF_FFFC advancing -> next addr=0. Assert rst_i mid-request (req=1, no ack) -> outputs zero and imem_req_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction
// memory and presents either a fetched instruction (with PC+4) or an all-zero
// bubble to the IF/ID register.
//
// Handshake: imem_req_o/imem_addr_o are held constant from the cycle the
// request is raised until the cycle imem_ack_i=1. That ack completes the read
// on the same rising edge. Any imem_ack_i seen while imem_req_o=0 is ignored.
//
// The FSM state is kept in state_q so that checkers can bind to it directly.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        hd_stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        fetch_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] pc_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DISCARD = 2'd2,
      ST_READY   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pending_q, pending_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   // Redirect decode: branch has priority over jump when both are asserted.
   always_comb begin
      redirect = branch_i | jump_i;
      target   = branch_i ? branch_target_i : jump_target_i;
      pc_plus4 = pc_q + 32'd4;
   end

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0;
         pending_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pending_q <= pending_d;
      end
   end

   // Next-state logic: a redirect always beats the hazard stall.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pending_d = pending_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack_i) begin
               if (redirect) begin
                  // Word belongs to the wrong path; refetch from the target.
                  pc_d = target;
               end else begin
                  instr_d = imem_rdata_i;
                  state_d = ST_READY;
               end
            end else if (redirect) begin
               // Request address must stay stable, so park the target.
               pending_d = target;
               state_d   = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (redirect) pending_d = target;
            if (imem_ack_i) begin
               pc_d    = redirect ? target : pending_q;
               state_d = ST_FETCH;
            end
         end
         ST_READY: begin
            if (redirect) begin
               pc_d    = target;
               state_d = ST_FETCH;
            end else if (!hd_stall_i) begin
               pc_d    = pc_plus4;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state so reset takes effect without a clock edge.
   always_comb begin
      imem_req_o    = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
      imem_addr_o   = pc_q;
      fetch_valid_o = (state_q == ST_READY);
      instr_o       = fetch_valid_o ? instr_q : 32'h0;
      pc_plus4_o    = fetch_valid_o ? pc_plus4 : 32'h0;
      pc_o          = pc_q;
   end

endmodule
